// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Multi-cycle shift sequencer. Loads an operand on an accepted
//                start, applies one left-shift step per clock for the captured
//                number of positions, then reports the result and the last bit
//                shifted out of the MSB.
//                Optional build macro SHIFT_SEQ_ROTATE_EN adds the 'rot' input,
//                which selects rotate-left instead of zero-fill per operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q,   reg_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic             cout_q,  cout_d;
    logic             fill_w;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot_q,   rot_d;

    // Bit entering the LSB: the departing MSB when rotating, else zero.
    assign fill_w = rot_q & reg_q[WIDTH-1];
`else
    assign fill_w = 1'b0;
`endif

    // State and datapath registers; reset dominates every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Next-state and datapath update: accept start only in IDLE/DONE, one
    // shift step per cycle in SHIFT, leave when the final step is taken.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    reg_d   = a;
                    cnt_d   = amt;
                    cout_d  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d   = rot;
`endif
                    state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                cout_d = reg_q[WIDTH-1];
                reg_d  = {reg_q[WIDTH-2:0], fill_w};
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode purely from registered state.
    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign result = reg_q;
    assign cout   = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl with a behavioural
//                reference model (closed-form shift/rotate arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] amt;
    logic             rot;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] last_res;
    logic             last_cout;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .amt    (amt),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rot    (rot),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: shifting left by n with zero fill multiplies by 2**n modulo
    // 2**WIDTH; rotation is the same modulo WIDTH positions with wrap.
    function automatic logic [WIDTH-1:0] model_result(input logic [WIDTH-1:0] op,
                                                       input int n, input logic r);
        longint v;
        int     m;
        v = longint'(op);
        if (!r) begin
            return WIDTH'((v * (longint'(1) << n)) % (longint'(1) << WIDTH));
        end
        m = n % WIDTH;
        if (m == 0) return op;
        return WIDTH'(((v << m) | (v >> (WIDTH - m))) % (longint'(1) << WIDTH));
    endfunction

    // Bit leaving the MSB on step n (1-based) is original bit WIDTH-n; beyond
    // WIDTH steps zero-fill only shifts out zeros, rotation wraps around.
    function automatic logic model_cout(input logic [WIDTH-1:0] op,
                                        input int n, input logic r);
        int idx;
        if (n == 0) return 1'b0;
        if (!r) begin
            if (n > WIDTH) return 1'b0;
            idx = WIDTH - n;
        end else begin
            idx = WIDTH - 1 - ((n - 1) % WIDTH);
        end
        return op[idx];
    endfunction

    // Issues start at the current negedge and follows the operation to DONE,
    // checking busy/done every cycle. Returns at the negedge where done is
    // first high. inj_k pulses start mid-shift at cycle inj_k (0 = never).
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [AMT_W-1:0] op_amt,
                          input logic op_rot, input int inj_k);
        logic [WIDTH-1:0] er;
        logic             ec;
        int               n;
        logic             eff_rot;
        n = int'(op_amt);
`ifdef SHIFT_SEQ_ROTATE_EN
        eff_rot = op_rot;
`else
        eff_rot = 1'b0;
`endif
        er = model_result(op_a, n, eff_rot);
        ec = model_cout(op_a, n, eff_rot);
        start = 1'b1;
        a     = op_a;
        amt   = op_amt;
        rot   = op_rot;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n + 1; k++) begin
            a   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            amt = AMT_W'($urandom_range(0, (1 << AMT_W) - 1));
            rot = 1'($urandom_range(0, 1));
            check("busy", 32'(busy), 32'(k <= n));
            check("done", 32'(done), 32'(k == n + 1));
            if (k == n + 1) begin
                check("result", 32'(result), 32'(er));
                check("cout", 32'(cout), 32'(ec));
            end else begin
                start = (k == inj_k);
                @(negedge clk);
                start = 1'b0;
            end
        end
        last_res  = er;
        last_cout = ec;
    endtask

    // Idle cycles in DONE with start low: state and outputs must hold.
    task automatic hold_done(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("hold_done", 32'(done), 32'd1);
            check("hold_busy", 32'(busy), 32'd0);
            check("hold_result", 32'(result), 32'(last_res));
            check("hold_cout", 32'(cout), 32'(last_cout));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        amt   = '0;
        rot   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);

        // Directed cases, including back-to-back restart from DONE.
        run_op(4'b1011, 3'd1, 1'b0, 0);
        hold_done(1);
        run_op(4'b1011, 3'd0, 1'b0, 0);
        run_op(4'b0001, 3'd3, 1'b0, 0);
        hold_done(2);
        run_op(4'b1111, 3'd5, 1'b0, 2);
        run_op(4'b1000, 3'd4, 1'b0, 0);
        run_op(4'b1100, 3'd7, 1'b0, 7);
        hold_done(1);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op(4'b1001, 3'd1, 1'b1, 0);
        run_op(4'b1001, 3'd4, 1'b1, 0);
        run_op(4'b1001, 3'd1, 1'b0, 0);
        run_op(4'b0110, 3'd7, 1'b1, 0);
        hold_done(1);
`endif

        // Reset during a long shift aborts it; no done without a new start.
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        amt   = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_no_busy", 32'(busy), 32'd0);
        end

        // Randomized operations with random idle gaps and mid-shift starts.
        for (int t = 0; t < 60; t++) begin
            logic [WIDTH-1:0] ra;
            logic [AMT_W-1:0] ramt;
            logic             rrot;
            int               gap;
            ra   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            ramt = AMT_W'($urandom_range(0, (1 << AMT_W) - 1));
            rrot = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            run_op(ra, ramt, rrot, $urandom_range(0, 8));
            hold_done(gap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
